// File: rtl/pds_target.sv
// pds_target -- 68000-style PDS bus responder serving a 4-word control/ID
// register window. Master cycles that hit the window are answered with nDTACK
// after WAIT_STATES extra C16M cycles. Writes honour the nUDS/nLDS byte lanes.
//
// Ports:
//   C16M      in   sole clock, all logic on posedge
//   RES       in   asynchronous active-high reset
//   nAS       in   bus address strobe (async to C16M)
//   nUDS      in   upper data strobe, D[15:8] (async)
//   nLDS      in   lower data strobe, D[7:0] (async)
//   RnW       in   1 = read, 0 = write (valid while nAS low)
//   A[23:1]   in   bus word address
//   Din       in   bus write data
//   Dout      out  read data to the bus drivers
//   nDoutOE   out  active-low enable for the Dout drivers
//   nDTACK    out  data acknowledge level
//   DTACK_OE  out  enable for the nDTACK tri-state driver
//
// Registers: 0..2 are read/write, 3 reads ID and ignores writes.

module pds_target #(
    parameter logic [23:0] BASE        = 24'hF00000,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] ID          = 16'h5E30
) (
    input  logic        C16M,
    input  logic        RES,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        RnW,
    input  logic [23:1] A,
    input  logic [15:0] Din,
    output logic [15:0] Dout,
    output logic        nDoutOE,
    output logic        nDTACK,
    output logic        DTACK_OE
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Strobe synchronisers (raw active-low levels; reset = deasserted)
    // ------------------------------------------------------------------
    logic nas_meta_q,  nas_sync_q;
    logic nuds_meta_q, nuds_sync_q;
    logic nlds_meta_q, nlds_sync_q;

    always_ff @(posedge C16M or posedge RES) begin
        if (RES) begin
            nas_meta_q  <= 1'b1;
            nas_sync_q  <= 1'b1;
            nuds_meta_q <= 1'b1;
            nuds_sync_q <= 1'b1;
            nlds_meta_q <= 1'b1;
            nlds_sync_q <= 1'b1;
        end else begin
            nas_meta_q  <= nAS;
            nas_sync_q  <= nas_meta_q;
            nuds_meta_q <= nUDS;
            nuds_sync_q <= nuds_meta_q;
            nlds_meta_q <= nLDS;
            nlds_sync_q <= nlds_meta_q;
        end
    end

    logic as_s, uds_s, lds_s;
    assign as_s  = ~nas_sync_q;
    assign uds_s = ~nuds_sync_q;
    assign lds_s = ~nlds_sync_q;

    // A, RnW and Din are used unsynchronised: the master holds them stable
    // for as long as the synchronised address strobe is active.
    logic       hit;
    logic [1:0] idx;
    assign hit = (A[23:3] == BASE[23:3]);
    assign idx = A[2:1];

    // ------------------------------------------------------------------
    // State, counter, registered outputs and register bank
    // ------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        ndtack_q,   ndtack_d;
    logic        dtack_oe_q, dtack_oe_d;
    logic        ndoe_q,     ndoe_d;
    logic [15:0] dout_q,     dout_d;
    logic [15:0] regs_q [0:2];
    logic [15:0] regs_d [0:2];

    always_ff @(posedge C16M or posedge RES) begin
        if (RES) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ndtack_q   <= 1'b1;
            dtack_oe_q <= 1'b0;
            ndoe_q     <= 1'b1;
            dout_q     <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ndtack_q   <= ndtack_d;
            dtack_oe_q <= dtack_oe_d;
            ndoe_q     <= ndoe_d;
            dout_q     <= dout_d;
            for (int unsigned i = 0; i < 3; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read mux for the current index
    logic [15:0] rd_data;

    always_comb begin
        rd_data = ID;
        for (int unsigned i = 0; i < 3; i++) begin
            if (idx == 2'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ndtack_d   = ndtack_q;
        dtack_oe_d = dtack_oe_q;
        ndoe_d     = ndoe_q;
        dout_d     = dout_q;
        for (int unsigned i = 0; i < 3; i++) begin
            regs_d[i] = regs_q[i];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (as_s) begin
                    if (hit) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT;
                    end else begin
                        state_d = ST_MISS;
                    end
                end
            end

            ST_MISS: begin
                if (!as_s) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (!as_s) begin
                    // Master gave up: nothing is written and nothing acked.
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (uds_s || lds_s) begin
                    // Read data and write commit both happen on this single
                    // edge, so a reset can never leave a half-written word.
                    state_d    = ST_ACK;
                    ndtack_d   = 1'b0;
                    dtack_oe_d = 1'b1;
                    if (RnW) begin
                        dout_d = rd_data;
                        ndoe_d = 1'b0;
                    end else begin
                        for (int unsigned i = 0; i < 3; i++) begin
                            if (idx == 2'(i)) begin
                                if (uds_s) regs_d[i][15:8] = Din[15:8];
                                if (lds_s) regs_d[i][7:0]  = Din[7:0];
                            end
                        end
                    end
                end
                // cnt==0 without a strobe: hold until the data strobes arrive.
            end

            ST_ACK: begin
                if (!as_s) begin
                    state_d  = ST_RELEASE;
                    ndtack_d = 1'b1;
                    ndoe_d   = 1'b1;
                end
            end

            ST_RELEASE: begin
                // nDTACK has been driven high for one cycle; now tri-state it.
                dtack_oe_d = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Dout     = dout_q;
    assign nDoutOE  = ndoe_q;
    assign nDTACK   = ndtack_q;
    assign DTACK_OE = dtack_oe_q;

endmodule

// File: tb/tb_pds_target.sv
module tb_pds_target;

    localparam logic [23:0] BASE = 24'hF00000;
    localparam logic [15:0] IDV  = 16'h5E30;

    logic        C16M;
    logic        RES;
    logic        nAS_a, nAS_b;
    logic        nUDS, nLDS, RnW;
    logic [23:1] A;
    logic [15:0] Din;

    logic [15:0] dout_a, dout_b;
    logic        ndoe_a, ndoe_b, ndtack_a, ndtack_b, oe_a, oe_b;

    pds_target #(.BASE(BASE), .WAIT_STATES(2), .ID(IDV)) u_dut (
        .C16M(C16M), .RES(RES), .nAS(nAS_a), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .A(A), .Din(Din), .Dout(dout_a), .nDoutOE(ndoe_a),
        .nDTACK(ndtack_a), .DTACK_OE(oe_a)
    );

    pds_target #(.BASE(BASE), .WAIT_STATES(8), .ID(IDV)) u_dut8 (
        .C16M(C16M), .RES(RES), .nAS(nAS_b), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .A(A), .Din(Din), .Dout(dout_b), .nDoutOE(ndoe_b),
        .nDTACK(ndtack_b), .DTACK_OE(oe_b)
    );

    initial C16M = 1'b0;
    always #5 C16M = ~C16M;

    // Which DUT the bus activity and the monitor are currently aimed at
    logic        cur_sel;
    logic        mon_ndtack, mon_oe, mon_ndoe;
    logic [15:0] mon_dout;
    assign mon_ndtack = cur_sel ? ndtack_b : ndtack_a;
    assign mon_oe     = cur_sel ? oe_b     : oe_a;
    assign mon_ndoe   = cur_sel ? ndoe_b   : ndoe_a;
    assign mon_dout   = cur_sel ? dout_b   : dout_a;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          rd;
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit rd, input logic [15:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic set_as(input bit sel, input logic v);
        if (sel) nAS_b = v;
        else     nAS_a = v;
    endtask

    // Monitor: every falling nDTACK is one presented response
    exp_t mon_e;
    initial begin : monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge C16M);
            if (prev && !mon_ndtack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ack_dtack_oe", {31'd0, mon_oe}, 32'd1);
                    if (mon_e.rd) begin
                        chk("rd_data", {16'd0, mon_dout}, {16'd0, mon_e.data});
                        chk("rd_ndoutoe", {31'd0, mon_ndoe}, 32'd0);
                    end else begin
                        chk("wr_ndoutoe", {31'd0, mon_ndoe}, 32'd1);
                    end
                end
            end
            prev = mon_ndtack;
        end
    end

    // One full master cycle. sdly = posedges after nAS before strobes drop.
    task automatic bus_cycle(input bit sel, input bit rnw, input logic [23:0] addr,
                             input logic [15:0] wdata, input bit uds, input bit lds,
                             input int sdly, input int ws, input bit expect_ack);
        int n, m, exp_lat;
        bit got, saw_oe;
        @(negedge C16M);
        cur_sel = sel;
        A   = addr[23:1];
        RnW = rnw;
        Din = wdata;
        if (expect_ack) push_exp(rnw, wdata);
        set_as(sel, 1'b0);
        if (sdly == 0) begin
            nUDS = ~uds;
            nLDS = ~lds;
        end
        n = 0; got = 1'b0; saw_oe = 1'b0;
        while (!got && n < 40) begin
            @(posedge C16M);
            n++;
            @(negedge C16M);
            if (n == sdly) begin
                nUDS = ~uds;
                nLDS = ~lds;
            end
            if (mon_oe) saw_oe = 1'b1;
            if (!mon_ndtack) got = 1'b1;
        end
        set_as(sel, 1'b1);
        nUDS = 1'b1;
        nLDS = 1'b1;
        if (expect_ack) begin
            exp_lat = (4 + ws > sdly + 3) ? 4 + ws : sdly + 3;
            chk("ack_seen", {31'd0, got}, 32'd1);
            if (got) begin
                chk("ack_latency", n, exp_lat);
                m = 0;
                while (!mon_ndtack && m < 10) begin
                    @(posedge C16M);
                    m++;
                    @(negedge C16M);
                end
                chk("release_latency", m, 3);
                chk("release_oe_held", {31'd0, mon_oe}, 32'd1);
                chk("release_ndoutoe", {31'd0, mon_ndoe}, 32'd1);
                @(posedge C16M);
                @(negedge C16M);
                chk("release_oe_off", {31'd0, mon_oe}, 32'd0);
            end
        end else begin
            chk("miss_no_ack", {31'd0, got}, 32'd0);
            chk("miss_no_oe", {31'd0, saw_oe}, 32'd0);
            repeat (4) @(posedge C16M);
        end
    endtask

    task automatic rd(input bit sel, input logic [23:0] addr, input logic [15:0] exp, input int ws);
        bus_cycle(sel, 1'b1, addr, exp, 1'b1, 1'b1, 0, ws, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit saw;
        int n;
        bit got;
        RES = 1'b1;
        nAS_a = 1'b1; nAS_b = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        RnW = 1'b1; A = '0; Din = '0; cur_sel = 1'b0;
        repeat (2) @(negedge C16M);
        chk("rst_ndtack", {31'd0, ndtack_a}, 32'd1);
        chk("rst_dtack_oe", {31'd0, oe_a}, 32'd0);
        chk("rst_ndoutoe", {31'd0, ndoe_a}, 32'd1);
        chk("rst_dout", {16'd0, dout_a}, 32'd0);
        chk("rst_ndtack_b", {31'd0, ndtack_b}, 32'd1);
        RES = 1'b0;
        repeat (2) @(negedge C16M);

        // ID read, strobes with nAS: ack after edge 6
        rd(0, BASE + 24'd6, 16'h5E30, 2);

        // Word write with strobes 2 cycles late, then one 5 cycles late
        bus_cycle(0, 1'b0, BASE + 24'd0, 16'hA55A, 1'b1, 1'b1, 2, 2, 1'b1);
        rd(0, BASE + 24'd0, 16'hA55A, 2);
        bus_cycle(0, 1'b0, BASE + 24'd4, 16'hBEEF, 1'b1, 1'b1, 5, 2, 1'b1);
        rd(0, BASE + 24'd4, 16'hBEEF, 2);

        // Byte lanes on reg1
        rd(0, BASE + 24'd2, 16'h0000, 2);
        bus_cycle(0, 1'b0, BASE + 24'd2, 16'h1234, 1'b1, 1'b0, 0, 2, 1'b1);
        rd(0, BASE + 24'd2, 16'h1200, 2);
        bus_cycle(0, 1'b0, BASE + 24'd2, 16'hABCD, 1'b0, 1'b1, 0, 2, 1'b1);
        rd(0, BASE + 24'd2, 16'h12CD, 2);

        // Misses just outside the window
        bus_cycle(0, 1'b1, BASE + 24'd8, 16'h0000, 1'b1, 1'b1, 0, 2, 1'b0);
        bus_cycle(0, 1'b0, BASE + 24'd8, 16'hDEAD, 1'b1, 1'b1, 0, 2, 1'b0);
        rd(0, BASE + 24'd0, 16'hA55A, 2);

        // ID register ignores writes
        bus_cycle(0, 1'b0, BASE + 24'd6, 16'hFFFF, 1'b1, 1'b1, 0, 2, 1'b1);
        rd(0, BASE + 24'd6, 16'h5E30, 2);

        // Back-to-back reads
        rd(0, BASE + 24'd0, 16'hA55A, 2);
        rd(0, BASE + 24'd2, 16'h12CD, 2);

        // Aborted write on the 8-wait-state instance
        bus_cycle(1, 1'b0, BASE + 24'd0, 16'h1111, 1'b1, 1'b1, 0, 8, 1'b1);
        @(negedge C16M);
        cur_sel = 1'b1;
        A = BASE[23:1]; RnW = 1'b0; Din = 16'h2222;
        nAS_b = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge C16M);
            @(negedge C16M);
            if (!mon_ndtack || mon_oe) saw = 1'b1;
        end
        nAS_b = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge C16M);
            @(negedge C16M);
            if (!mon_ndtack || mon_oe) saw = 1'b1;
        end
        chk("abort_no_ack", {31'd0, saw}, 32'd0);
        rd(1, BASE + 24'd0, 16'h1111, 8);

        // Reset asserted while a read is being acknowledged
        @(negedge C16M);
        cur_sel = 1'b0;
        A = (BASE + 24'd6) >> 1; RnW = 1'b1;
        push_exp(1'b1, 16'h5E30);
        nAS_a = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge C16M);
            n++;
            @(negedge C16M);
            if (!mon_ndtack) got = 1'b1;
        end
        chk("rstack_seen", {31'd0, got}, 32'd1);
        #2 RES = 1'b1;
        #1;
        chk("rstack_ndtack", {31'd0, ndtack_a}, 32'd1);
        chk("rstack_dtack_oe", {31'd0, oe_a}, 32'd0);
        chk("rstack_ndoutoe", {31'd0, ndoe_a}, 32'd1);
        chk("rstack_dout", {16'd0, dout_a}, 32'd0);
        @(negedge C16M);
        nAS_a = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        RES = 1'b0;
        repeat (2) @(negedge C16M);
        rd(0, BASE + 24'd0, 16'h0000, 2);
        rd(0, BASE + 24'd2, 16'h0000, 2);
        rd(0, BASE + 24'd4, 16'h0000, 2);
        rd(0, BASE + 24'd6, 16'h5E30, 2);

        repeat (4) @(negedge C16M);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pds_target.md
Name: pds_target

Overview:
- 68000-style PDS bus responder. It is the target-side counterpart of the IO bus initiator.
- Decodes a 4-word register window and answers master cycles with nDTACK after a programmable number of wait states.
- Supports byte-lane writes via nUDS/nLDS.
- Sits on the PDS bus beside the card's bus interface CPLD logic and serves a small control/ID register bank.

Parameters:
- BASE, 24'hF00000: window base byte address; A[23:3] compared against BASE[23:3].
- WAIT_STATES, 2: extra C16M cycles inserted between address hit and nDTACK assertion; range 0..15.
- ID, 16'h5E30: read-only value of register 3.

Ports:
- C16M  input  1  sole clock, all logic on posedge.
- RES  input  1  asynchronous active-high reset.
- nAS  input  1  bus address strobe, asynchronous to C16M.
- nUDS  input  1  upper data strobe (D[15:8]), asynchronous.
- nLDS  input  1  lower data strobe (D[7:0]), asynchronous.
- RnW  input  1  1 = read, 0 = write; valid while nAS low.
- A  input  23  bus address A[23:1].
- Din  input  16  bus write data.
- Dout  output  16  read data to bus drivers.
- nDoutOE  output  1  active-low enable for the Dout bus drivers.
- nDTACK  output  1  data acknowledge level.
- DTACK_OE  output  1  enable for the nDTACK open-drain/tri-state driver.

Behaviour:
- Reset (RES high, async): state IDLE, nDTACK=1, DTACK_OE=0, nDoutOE=1, Dout=0, regs 0..2 = 16'h0000, sync flops = deasserted.
- Synchronisers:
  - nAS, nUDS and nLDS each pass through a 2-flop chain.
  - Synchronised actives are ASs, UDSs and LDSs.
  - A, RnW and Din are sampled directly, because they are stable while ASs=1.
- Hit: A[23:3]==BASE[23:3]. Register index = A[2:1].
- State machine:
  - IDLE:
    - ASs=1 and hit -> WAIT, cnt<=WAIT_STATES.
    - ASs=1 and miss -> MISS.
    - Otherwise stay.
  - MISS: no outputs driven; ASs=0 -> IDLE.
  - WAIT:
    - ASs=0 (aborted cycle) -> IDLE; no write, no ack.
    - cnt!=0 -> decrement cnt.
    - cnt==0 and (UDSs or LDSs) -> ACK, and on this edge:
      - nDTACK<=0, DTACK_OE<=1.
      - Read: Dout<=reg[idx], nDoutOE<=0.
      - Write: reg[idx][15:8]<=Din[15:8] if UDSs; reg[idx][7:0]<=Din[7:0] if LDSs.
    - cnt==0 with no strobe -> hold in WAIT. This covers write cycles, where data strobes lag nAS.
  - ACK: hold outputs; ASs=0 -> RELEASE with nDTACK<=1, nDoutOE<=1.
  - RELEASE: DTACK_OE<=0 (nDTACK driven high for exactly one cycle before tri-state) -> IDLE.
- Register 3 reads ID. Writes to register 3 are acked but discarded.
- Latency:
  - The nAS falling edge is first sampled at edge 1.
  - nDTACK goes low after edge 4+WAIT_STATES, provided a strobe is already synchronised.
  - nDTACK returns high 3 edges after nAS is seen high at edge 1.
- Back-to-back cycles: a new ASs while in RELEASE is taken from IDLE on the next edge. No cycle is ever merged with a previous one.
- RES asserted mid-cycle: outputs go to reset values immediately and the bus is released. A partially committed write is not possible, because the write is a single-edge commit.

Test Plan:
- Reset: assert RES mid-ACK -> nDTACK=1, DTACK_OE=0, nDoutOE=1 immediately; regs 0..2 read 0000 afterwards.
- Read ID: read of A=BASE+6, WAIT_STATES=2, strobes with nAS -> nDTACK low after edge 6, Dout=5E30, nDoutOE=0; nAS high -> nDTACK high 3 edges later, one cycle driven high, then DTACK_OE=0.
- Word write: write 16'hA55A to BASE+0, strobes 2 cycles after nAS -> ack waits for strobes; readback returns A55A.
- Byte lanes: write 16'h1234 to BASE+2 with only nUDS low, reg1 previously 0000 -> reg1=1200; then write 16'hABCD with only nLDS low -> reg1=12CD.
- Miss and abort:
  - Access to BASE+8 -> nDTACK never asserted, DTACK_OE stays 0.
  - Hit write whose nAS rises during WAIT (WAIT_STATES=8) -> no ack, register unchanged.
- ID protection and back-to-back: write FFFF to BASE+6 -> acked, readback 5E30; two reads separated by one idle C16M -> both acked correctly, no merged cycle.
